// File: rtl/profile_step_ctrl.sv
// profile_step_ctrl: acc_step sequencer and parameter write
// queue in front of profile_gen.
module profile_step_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int PERIOD_W   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PERIOD_W-1:0]           step_period,
  input  logic                          step_req,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_barrier,
  input  logic [7:0]                    cmd_addr,
  input  logic [63:0]                   cmd_data,
  input  logic                          pg_busy,
  output logic                          acc_step,
  output logic [7:0]                    param_addr,
  output logic [31:0]                   param_in,
  output logic                          param_write_lo,
  output logic                          param_write_hi,
  output logic [31:0]                   step_count,
  output logic [15:0]                   overrun_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          ctrl_idle
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic        barrier;
    logic [7:0]  addr;
    logic [63:0] data;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_LO,
    S_WR_HI,
    S_STEP,
    S_HOLD
  } state_t;

  entry_t              mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q;
  logic [AW-1:0]       rd_ptr_q;
  logic [LW-1:0]       level_q;
  logic [LW-1:0]       level_d;
  entry_t              head;
  logic                empty;
  logic                full;
  logic                push;
  logic                pop;
  logic                pop_wr;
  logic                pop_bar;
  logic                go_step;

  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] cnt_d;
  logic                tick;
  logic                ev;

  state_t              state_q;
  logic                pend_q;
  logic [31:0]         step_cnt_q;
  logic [15:0]         ovr_q;
  logic                acc_q;
  logic                wlo_q;
  logic                whi_q;
  logic [7:0]          addr_q;
  logic [31:0]         pin_q;
  logic [31:0]         hi_q;

  assign head    = mem_q[rd_ptr_q];
  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(FIFO_DEPTH));
  assign push    = cmd_valid && !full;
  assign go_step = (state_q == S_IDLE) && pend_q && !pg_busy;
  assign pop_wr  = (state_q == S_IDLE) && !empty
                && !head.barrier && !pend_q && !pg_busy;
  assign pop_bar = (state_q == S_STEP) && !empty
                && head.barrier;
  assign pop     = pop_wr || pop_bar;
  assign ev      = tick || step_req;

  // Next FIFO occupancy from push/pop of this cycle
  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Period timer; out-of-range counter after a period change
  // restarts silently without a tick
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (step_period == '0) begin
      cnt_d = '0;
    end else if (cnt_q >= step_period) begin
      cnt_d = '0;
    end else if (cnt_q == step_period - PERIOD_W'(1)) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + PERIOD_W'(1);
    end
  end

  // Command storage, no reset needed on the array
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{cmd_barrier, cmd_addr, cmd_data};
    end
  end

  // FIFO pointers and level
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  // Timer, pending tick, step and overrun counters
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      step_cnt_q <= '0;
      ovr_q      <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (state_q == S_STEP) begin
        pend_q     <= ev;
        step_cnt_q <= step_cnt_q + 32'd1;
      end else if (ev) begin
        pend_q <= 1'b1;
        if ((pend_q || (tick && step_req))
            && (ovr_q != 16'hFFFF)) begin
          ovr_q <= ovr_q + 16'd1;
        end
      end
    end
  end

  // Sequencer FSM with registered strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= 1'b0;
      wlo_q   <= 1'b0;
      whi_q   <= 1'b0;
      addr_q  <= '0;
      pin_q   <= '0;
      hi_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (go_step) begin
            state_q <= S_STEP;
            acc_q   <= 1'b1;
          end else if (pop_wr) begin
            state_q <= S_WR_LO;
            wlo_q   <= 1'b1;
            addr_q  <= head.addr;
            pin_q   <= head.data[31:0];
            hi_q    <= head.data[63:32];
          end
        end
        S_WR_LO: begin
          state_q <= S_WR_HI;
          wlo_q   <= 1'b0;
          whi_q   <= 1'b1;
          pin_q   <= hi_q;
        end
        S_WR_HI: begin
          state_q <= S_IDLE;
          whi_q   <= 1'b0;
        end
        S_STEP: begin
          state_q <= S_HOLD;
          acc_q   <= 1'b0;
        end
        S_HOLD: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          acc_q   <= 1'b0;
          wlo_q   <= 1'b0;
          whi_q   <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready      = !full;
  assign acc_step       = acc_q;
  assign param_addr     = addr_q;
  assign param_in       = pin_q;
  assign param_write_lo = wlo_q;
  assign param_write_hi = whi_q;
  assign step_count     = step_cnt_q;
  assign overrun_count  = ovr_q;
  assign fifo_level     = level_q;
  assign ctrl_idle      = empty && !pend_q
                       && (state_q == S_IDLE) && !pg_busy;

endmodule

// File: tb/tb_profile_step_ctrl.sv
// tb_profile_step_ctrl: directed bench for the step
// sequencer and parameter write queue.
module tb_profile_step_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] step_period;
  logic        step_req;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_barrier;
  logic [7:0]  cmd_addr;
  logic [63:0] cmd_data;
  logic        pg_busy;
  logic        acc_step;
  logic [7:0]  param_addr;
  logic [31:0] param_in;
  logic        param_write_lo;
  logic        param_write_hi;
  logic [31:0] step_count;
  logic [15:0] overrun_count;
  logic [4:0]  fifo_level;
  logic        ctrl_idle;

  int checks;
  int errors;

  profile_step_ctrl #(
    .FIFO_DEPTH(16),
    .PERIOD_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .step_period(step_period),
    .step_req(step_req),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_barrier(cmd_barrier),
    .cmd_addr(cmd_addr),
    .cmd_data(cmd_data),
    .pg_busy(pg_busy),
    .acc_step(acc_step),
    .param_addr(param_addr),
    .param_in(param_in),
    .param_write_lo(param_write_lo),
    .param_write_hi(param_write_hi),
    .step_count(step_count),
    .overrun_count(overrun_count),
    .fifo_level(fifo_level),
    .ctrl_idle(ctrl_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // Strobes are mutually exclusive every cycle
  always @(negedge clk) begin
    if (!rst && (acc_step || param_write_lo
                 || param_write_hi)) begin
      checks++;
      assert ($onehot({acc_step, param_write_lo,
                       param_write_hi})) else begin
        errors++;
        $error("FAIL excl: observed %b expected onehot",
               {acc_step, param_write_lo, param_write_hi});
      end
    end
  end

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    step_period = '0;
    step_req    = 1'b0;
    cmd_valid   = 1'b0;
    cmd_barrier = 1'b0;
    cmd_addr    = '0;
    cmd_data    = '0;
    pg_busy     = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_idle", 64'(ctrl_idle), 64'd1);
    chk("rst_acc", 64'(acc_step), 64'd0);
    chk("rst_wlo", 64'(param_write_lo), 64'd0);
    chk("rst_whi", 64'(param_write_hi), 64'd0);
    chk("rst_addr", 64'(param_addr), 64'd0);
    chk("rst_pin", 64'(param_in), 64'd0);
    chk("rst_steps", 64'(step_count), 64'd0);
    chk("rst_ovr", 64'(overrun_count), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 64'(ctrl_idle), 64'd1);

    // Timer at period 100
    step_period = 16'd100;
    repeat (400) @(negedge clk);
    chk("t100_e400_acc", 64'(acc_step), 64'd0);
    @(negedge clk);
    chk("t100_e401_acc", 64'(acc_step), 64'd1);
    repeat (99) @(negedge clk);
    chk("t100_e500_acc", 64'(acc_step), 64'd0);
    chk("t100_e500_steps", 64'(step_count), 64'd4);
    @(negedge clk);
    chk("t100_e501_acc", 64'(acc_step), 64'd1);
    @(negedge clk);
    chk("t100_e502_acc", 64'(acc_step), 64'd0);
    chk("t100_steps", 64'(step_count), 64'd5);
    chk("t100_ovr", 64'(overrun_count), 64'd0);
    step_period = '0;
    repeat (3) @(negedge clk);
    chk("t100_idle", 64'(ctrl_idle), 64'd1);

    // Single write
    cmd_valid   = 1'b1;
    cmd_barrier = 1'b0;
    cmd_addr    = 8'h24;
    cmd_data    = 64'h1122334455667788;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("w1_level", 64'(fifo_level), 64'd1);
    chk("w1_nolo", 64'(param_write_lo), 64'd0);
    @(negedge clk);
    chk("w1_lo", 64'(param_write_lo), 64'd1);
    chk("w1_lo_addr", 64'(param_addr), 64'h24);
    chk("w1_lo_data", 64'(param_in), 64'h55667788);
    chk("w1_lo_level", 64'(fifo_level), 64'd0);
    @(negedge clk);
    chk("w1_hi", 64'(param_write_hi), 64'd1);
    chk("w1_hi_nolo", 64'(param_write_lo), 64'd0);
    chk("w1_hi_addr", 64'(param_addr), 64'h24);
    chk("w1_hi_data", 64'(param_in), 64'h11223344);
    @(negedge clk);
    chk("w1_done_hi", 64'(param_write_hi), 64'd0);
    chk("w1_idle", 64'(ctrl_idle), 64'd1);

    // W1, barrier, W2 around a manual step
    cmd_valid   = 1'b1;
    cmd_barrier = 1'b0;
    cmd_addr    = 8'h01;
    cmd_data    = 64'hAAAA0001BBBB0001;
    @(negedge clk);
    cmd_barrier = 1'b1;
    cmd_addr    = 8'h00;
    cmd_data    = '0;
    @(negedge clk);
    chk("b_w1_lo", 64'(param_write_lo), 64'd1);
    chk("b_w1_addr", 64'(param_addr), 64'h01);
    chk("b_w1_data", 64'(param_in), 64'hBBBB0001);
    cmd_barrier = 1'b0;
    cmd_addr    = 8'h02;
    cmd_data    = 64'hCCCC0002DDDD0002;
    @(negedge clk);
    chk("b_w1_hi", 64'(param_write_hi), 64'd1);
    chk("b_w1_hdata", 64'(param_in), 64'hAAAA0001);
    cmd_valid = 1'b0;
    chk("b_level2", 64'(fifo_level), 64'd2);
    @(negedge clk);
    chk("b_blk_lo", 64'(param_write_lo), 64'd0);
    chk("b_blk_hi", 64'(param_write_hi), 64'd0);
    chk("b_blk_level", 64'(fifo_level), 64'd2);
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    chk("b_req_acc0", 64'(acc_step), 64'd0);
    @(negedge clk);
    chk("b_acc", 64'(acc_step), 64'd1);
    chk("b_acc_level", 64'(fifo_level), 64'd2);
    pg_busy = 1'b1;
    @(negedge clk);
    chk("b_acc_off", 64'(acc_step), 64'd0);
    chk("b_bar_pop", 64'(fifo_level), 64'd1);
    chk("b_steps", 64'(step_count), 64'd6);
    repeat (29) @(negedge clk);
    chk("b_busy_level", 64'(fifo_level), 64'd1);
    chk("b_busy_nolo", 64'(param_write_lo), 64'd0);
    chk("b_busy_nidle", 64'(ctrl_idle), 64'd0);
    pg_busy = 1'b0;
    @(negedge clk);
    chk("b_w2_lo", 64'(param_write_lo), 64'd1);
    chk("b_w2_addr", 64'(param_addr), 64'h02);
    chk("b_w2_data", 64'(param_in), 64'hDDDD0002);
    chk("b_w2_level", 64'(fifo_level), 64'd0);
    @(negedge clk);
    chk("b_w2_hi", 64'(param_write_hi), 64'd1);
    chk("b_w2_hdata", 64'(param_in), 64'hCCCC0002);
    @(negedge clk);
    chk("b_idle", 64'(ctrl_idle), 64'd1);

    // Overruns while profile_gen is busy
    pg_busy     = 1'b1;
    step_period = 16'd10;
    repeat (35) @(negedge clk);
    chk("o_acc0", 64'(acc_step), 64'd0);
    chk("o_ovr", 64'(overrun_count), 64'd2);
    pg_busy = 1'b0;
    @(negedge clk);
    chk("o_acc1", 64'(acc_step), 64'd1);
    chk("o_ovr_keep", 64'(overrun_count), 64'd2);
    step_period = '0;
    @(negedge clk);
    chk("o_acc_off", 64'(acc_step), 64'd0);
    chk("o_steps", 64'(step_count), 64'd7);
    repeat (3) @(negedge clk);
    chk("o_idle", 64'(ctrl_idle), 64'd1);
    chk("o_single", 64'(step_count), 64'd7);

    // Fill the FIFO while blocked, then drain
    pg_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cmd_valid   = 1'b1;
      cmd_barrier = 1'b0;
      cmd_addr    = 8'h40 + 8'(i);
      cmd_data    = {32'hA0000000 | 32'(i),
                     32'h50000000 | 32'(i)};
      @(negedge clk);
    end
    chk("f_full_ready", 64'(cmd_ready), 64'd0);
    chk("f_full_level", 64'(fifo_level), 64'd16);
    cmd_addr = 8'hEE;
    cmd_data = 64'hDEADDEADDEADDEAD;
    @(negedge clk);
    chk("f_ovf_level", 64'(fifo_level), 64'd16);
    cmd_valid = 1'b0;
    pg_busy   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("f_lo", 64'(param_write_lo), 64'd1);
      chk("f_lo_addr", 64'(param_addr),
          64'(8'h40 + 8'(i)));
      chk("f_lo_data", 64'(param_in),
          64'(32'h50000000 | 32'(i)));
      if (i == 0) begin
        chk("f_ready1", 64'(cmd_ready), 64'd1);
        chk("f_level15", 64'(fifo_level), 64'd15);
      end
      @(negedge clk);
      chk("f_hi", 64'(param_write_hi), 64'd1);
      chk("f_hi_data", 64'(param_in),
          64'(32'hA0000000 | 32'(i)));
      @(negedge clk);
      chk("f_gap", 64'({param_write_lo,
                        param_write_hi}), 64'd0);
    end
    chk("f_idle", 64'(ctrl_idle), 64'd1);

    // Step request landing during the low half
    cmd_valid   = 1'b1;
    cmd_barrier = 1'b0;
    cmd_addr    = 8'h33;
    cmd_data    = 64'h0000777700008888;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("s_lo", 64'(param_write_lo), 64'd1);
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    chk("s_hi", 64'(param_write_hi), 64'd1);
    chk("s_hi_data", 64'(param_in), 64'h00007777);
    chk("s_hi_acc0", 64'(acc_step), 64'd0);
    @(negedge clk);
    chk("s_idle_acc0", 64'(acc_step), 64'd0);
    chk("s_idle_nwr", 64'({param_write_lo,
                           param_write_hi}), 64'd0);
    @(negedge clk);
    chk("s_acc", 64'(acc_step), 64'd1);
    @(negedge clk);
    chk("s_acc_off", 64'(acc_step), 64'd0);
    chk("s_steps", 64'(step_count), 64'd8);
    chk("s_ovr", 64'(overrun_count), 64'd2);
    repeat (2) @(negedge clk);
    chk("s_idle", 64'(ctrl_idle), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
